lsu_mem_port: RTL and testbench

Parametrised load/store unit that sits between the core's execute stage and the data-memory port. It replaces the fixed single-cycle store path with a handshaked, multi-cycle access engine. It supports byte, half, word and double loads and stores, signed and unsigned loads, lane-aligned write masks, misalignment detection and a bus timeout. One request is in flight at a time; the core stalls on `req_ready`.

---
 rtl/lsu_mem_port.sv | 213 +++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit between the execute stage and the data-memory
// port. One access in flight at a time; the core stalls on req_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_*                 core request (valid/ready handshake, accepted in IDLE)
//   rsp_*                 response to core (held until rsp_ready)
//   mem_*                 data-memory port (mem_ack completes an access)
//
// state | meaning
// IDLE  | ready for a new request
// BUSY  | memory access outstanding, waiting for mem_ack or timeout
// RESP  | response presented, waiting for rsp_ready
module lsu_mem_port #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  input  logic [4:0]           req_rd,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic [4:0]           rsp_rd,
  output logic                 rsp_wb,
  output logic                 rsp_err,
  output logic                 mem_valid,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [XLEN/8-1:0]    mem_wmask,
  input  logic                 mem_ack,
  input  logic [XLEN-1:0]      mem_rdata
);

  localparam int BUS_BYTES = XLEN / 8;
  localparam int OFS_W     = $clog2(BUS_BYTES);
  localparam int TMR_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [1:0]           size_q, size_d;
  logic [OFS_W-1:0]     ofs_q, ofs_d;
  logic                 uns_q, uns_d;
  logic                 mem_we_q, mem_we_d;
  logic [XLEN-1:0]      mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]      mem_wdata_q, mem_wdata_d;
  logic [BUS_BYTES-1:0] mem_wmask_q, mem_wmask_d;
  logic [XLEN-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic [4:0]           rsp_rd_q, rsp_rd_d;
  logic                 rsp_wb_q, rsp_wb_d;
  logic                 rsp_err_q, rsp_err_d;

  // Request decode, evaluated against the live request in IDLE.
  logic                 req_err;
  logic [15:0]          lane_bits;
  logic [BUS_BYTES-1:0] req_mask;
  logic [XLEN-1:0]      wdata_shift;
  logic [XLEN-1:0]      wdata_lane;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'd1:    req_err = req_addr[0];
      2'd2:    req_err = |req_addr[1:0];
      2'd3:    req_err = (|req_addr[2:0]) || (XLEN == 32);
      default: req_err = 1'b0;
    endcase
    lane_bits   = (16'd1 << (5'd1 << req_size)) - 16'd1;
    req_mask    = BUS_BYTES'(lane_bits) << req_addr[OFS_W-1:0];
    wdata_shift = req_wdata << {req_addr[OFS_W-1:0], 3'b000};
    wdata_lane  = '0;
    for (int i = 0; i < XLEN; i++) begin
      wdata_lane[i] = wdata_shift[i] & req_mask[i/8];
    end
  end

  // Load extraction from the latched lane offset and size. Size 3 is always
  // full width, so its unsigned flag makes no difference.
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] load_ext;
  logic            load_sign;

  always_comb begin
    rd_shift = mem_rdata >> {ofs_q, 3'b000};
    case (size_q)
      2'd0:    load_sign = rd_shift[7];
      2'd1:    load_sign = rd_shift[15];
      2'd2:    load_sign = rd_shift[31];
      default: load_sign = rd_shift[XLEN-1];
    endcase
    load_ext = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (i < (8 << size_q)) load_ext[i] = rd_shift[i];
      else                   load_ext[i] = load_sign & ~uns_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    size_d      = size_q;
    ofs_d       = ofs_q;
    uns_d       = uns_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_wb_d    = rsp_wb_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d      = req_size;
          ofs_d       = req_addr[OFS_W-1:0];
          uns_d       = req_unsigned;
          rsp_rd_d    = req_rd;
          rsp_rdata_d = '0;
          rsp_wb_d    = 1'b0;
          timer_d     = '0;
          if (req_err) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            rsp_err_d   = 1'b0;
            state_d     = BUSY;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[XLEN-1:OFS_W], {OFS_W{1'b0}}};
            mem_wmask_d = req_we ? req_mask : '0;
            mem_wdata_d = req_we ? wdata_lane : '0;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          // An ack in the final timeout cycle still completes normally.
          state_d = RESP;
          if (!mem_we_q) begin
            rsp_rdata_d = load_ext;
            rsp_wb_d    = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
          if (TIMEOUT != 0 && timer_d == TMR_W'(TIMEOUT)) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      size_q      <= '0;
      ofs_q       <= '0;
      uns_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      rsp_rdata_q <= '0;
      rsp_rd_q    <= '0;
      rsp_wb_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      size_q      <= size_d;
      ofs_q       <= ofs_d;
      uns_q       <= uns_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_wb_q    <= rsp_wb_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mem_valid = (state_q == BUSY);
  assign rsp_valid = (state_q == RESP);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_wb    = rsp_wb_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 64-bit instance
  logic        req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic [4:0]  req_rd = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_wb, rsp_err;
  logic [63:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        mem_valid, mem_we, mem_ack = 0;
  logic [63:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [7:0]  mem_wmask;

  // 32-bit instance
  logic        s_req_valid = 0, s_req_ready, s_req_we = 0, s_req_unsigned = 0;
  logic [1:0]  s_req_size = 0;
  logic [31:0] s_req_addr = 0, s_req_wdata = 0;
  logic [4:0]  s_req_rd = 0;
  logic        s_rsp_valid, s_rsp_ready = 0, s_rsp_wb, s_rsp_err;
  logic [31:0] s_rsp_rdata;
  logic [4:0]  s_rsp_rd;
  logic        s_mem_valid, s_mem_we, s_mem_ack = 0;
  logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata = 0;
  logic [3:0]  s_mem_wmask;

  int n_cmp = 0;
  int n_err = 0;

  lsu_mem_port #(.XLEN(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_rd(rsp_rd), .rsp_wb(rsp_wb), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  lsu_mem_port #(.XLEN(32), .TIMEOUT(TO)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we),
    .req_size(s_req_size), .req_unsigned(s_req_unsigned), .req_addr(s_req_addr),
    .req_wdata(s_req_wdata), .req_rd(s_req_rd),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_rdata(s_rsp_rdata),
    .rsp_rd(s_rsp_rd), .rsp_wb(s_rsp_wb), .rsp_err(s_rsp_err),
    .mem_valid(s_mem_valid), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_wmask(s_mem_wmask), .mem_ack(s_mem_ack),
    .mem_rdata(s_mem_rdata)
  );

  // ---------------- reference model (byte-oriented) ----------------
  function automatic bit ref_misaligned(logic [63:0] addr, int size);
    return (addr % (64'd1 << size)) != 0;
  endfunction

  function automatic logic [63:0] ref_load(logic [63:0] rdata, int ofs, int size, bit uns);
    int n = 1 << size;
    logic [63:0] v = '0;
    for (int b = 0; b < n; b++) v[8*b +: 8] = rdata[8*(ofs+b) +: 8];
    if ((!uns || size == 3) && v[8*n-1])
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] ref_mask(int ofs, int size);
    logic [7:0] m = '0;
    for (int i = 0; i < 8; i++) if (i >= ofs && i < ofs + (1 << size)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] ref_wdata(logic [63:0] wd, int ofs, int size);
    logic [63:0] v = '0;
    for (int b = 0; b < (1 << size); b++) v[8*(ofs+b) +: 8] = wd[8*b +: 8];
    return v;
  endfunction

  // ---------------- stimulus driver (returns observations only) ----------------
  // Entered and left on a falling edge. ack_after = n acks in the n-th BUSY
  // cycle; 0 never acks. hold = cycles rsp_ready is held low in RESP.
  task automatic run_access(
    input bit we, input logic [1:0] size, input bit uns, input logic [63:0] addr,
    input logic [63:0] wdata, input logic [4:0] rd, input int ack_after,
    input logic [63:0] rdata, input int hold,
    output int busy, output logic [63:0] o_addr, output logic [63:0] o_wdata,
    output logic [7:0] o_mask, output bit o_we, output bit o_rsp_valid,
    output logic [63:0] o_rdata, output logic [4:0] o_rd, output bit o_wb,
    output bit o_err, output bit o_stable, output bit o_ready_after, output int total);
    busy = 0; total = 0; o_stable = 1;
    o_addr = '0; o_wdata = '0; o_mask = '0; o_we = 0;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr;
    req_wdata = wdata; req_rd = rd; req_valid = 1;
    @(negedge clk); total++;
    req_valid = 0;
    req_wdata = {$urandom, $urandom};
    req_addr  = {$urandom, $urandom};
    while (mem_valid === 1'b1 && busy < 300) begin
      busy++;
      if (busy == 1) begin
        o_addr = mem_addr; o_wdata = mem_wdata; o_mask = mem_wmask; o_we = mem_we;
      end else if (mem_addr !== o_addr || mem_wdata !== o_wdata ||
                   mem_wmask !== o_mask || mem_we !== o_we) begin
        o_stable = 0;
      end
      mem_ack   = (busy == ack_after);
      mem_rdata = (busy == ack_after) ? rdata : {$urandom, $urandom};
      @(negedge clk); total++;
      mem_ack = 0;
    end
    o_rsp_valid = rsp_valid; o_rdata = rsp_rdata; o_rd = rsp_rd;
    o_wb = rsp_wb; o_err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); total++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== o_rdata ||
          rsp_rd !== o_rd || rsp_wb !== o_wb || rsp_err !== o_err) o_stable = 0;
    end
    rsp_ready = 1;
    @(negedge clk); total++;
    rsp_ready = 0;
    o_ready_after = req_ready;
  endtask

  int busy, total;
  logic [63:0] o_addr, o_wdata, o_rdata;
  logic [7:0]  o_mask;
  logic [4:0]  o_rd;
  bit o_we, o_rv, o_wb, o_err, o_stable, o_rdy;

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++;
    if ({req_ready, s_req_ready} !== 2'b11) begin
      n_err++; $display("FAIL reset_req_ready: got %b want 11", {req_ready, s_req_ready});
    end
    n_cmp++;
    if ({mem_valid, rsp_valid, mem_we, rsp_wb, rsp_err, s_mem_valid, s_rsp_valid} !== 7'd0) begin
      n_err++; $display("FAIL reset_flags: got %b want 0",
        {mem_valid, rsp_valid, mem_we, rsp_wb, rsp_err, s_mem_valid, s_rsp_valid});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_wmask, rsp_rdata, rsp_rd} !== '0) begin
      n_err++; $display("FAIL reset_data: got addr=%h wdata=%h mask=%h rdata=%h rd=%0d want all 0",
        mem_addr, mem_wdata, mem_wmask, rsp_rdata, rsp_rd);
    end
  endtask

  task automatic test_byte_load();
    for (int u = 0; u < 2; u++) begin
      logic [63:0] exp = u ? 64'h88 : 64'hFFFF_FFFF_FFFF_FF88;
      run_access(0, 2'd0, u[0], 64'h8000_1003, 64'h0, 5'd5, 2, 64'h1122_3344_8877_6655, 0,
        busy, o_addr, o_wdata, o_mask, o_we, o_rv, o_rdata, o_rd, o_wb, o_err, o_stable, o_rdy, total);
      n_cmp++;
      if (o_addr !== 64'h8000_1000 || o_mask !== 8'h00 || o_we !== 1'b0) begin
        n_err++; $display("FAIL byte_load_mem: got addr=%h mask=%h we=%b want 80001000/00/0", o_addr, o_mask, o_we);
      end
      n_cmp++;
      if (o_rdata !== exp || o_rd !== 5'd5 || o_wb !== 1'b1 || o_err !== 1'b0 || busy != 2) begin
        n_err++; $display("FAIL byte_load_rsp u=%0d: got rdata=%h rd=%0d wb=%b err=%b busy=%0d want %h/5/1/0/2",
          u, o_rdata, o_rd, o_wb, o_err, busy, exp);
      end
    end
  endtask

  task automatic test_half_store();
    run_access(1, 2'd1, 0, 64'h8000_1006, 64'h1234_0000_0000_ABCD, 5'd7, 1, 64'h0, 0,
      busy, o_addr, o_wdata, o_mask, o_we, o_rv, o_rdata, o_rd, o_wb, o_err, o_stable, o_rdy, total);
    n_cmp++;
    if (o_we !== 1'b1 || o_mask !== 8'b1100_0000 || o_wdata !== 64'hABCD_0000_0000_0000 ||
        o_addr !== 64'h8000_1000) begin
      n_err++; $display("FAIL half_store_mem: got we=%b mask=%b wdata=%h addr=%h want 1/11000000/abcd000000000000/80001000",
        o_we, o_mask, o_wdata, o_addr);
    end
    n_cmp++;
    if (o_wb !== 1'b0 || o_err !== 1'b0 || o_rdata !== 64'h0 || o_rv !== 1'b1) begin
      n_err++; $display("FAIL half_store_rsp: got wb=%b err=%b rdata=%h valid=%b want 0/0/0/1", o_wb, o_err, o_rdata, o_rv);
    end
  endtask

  task automatic test_misaligned();
    bit saw_mem;
    run_access(0, 2'd2, 0, 64'h8000_1002, 64'h0, 5'd9, 1, 64'h0, 0,
      busy, o_addr, o_wdata, o_mask, o_we, o_rv, o_rdata, o_rd, o_wb, o_err, o_stable, o_rdy, total);
    n_cmp++;
    if (busy != 0 || o_rv !== 1'b1 || o_err !== 1'b1 || o_wb !== 1'b0 || o_rdata !== 64'h0 || total != 2) begin
      n_err++; $display("FAIL misaligned_64: got busy=%0d valid=%b err=%b wb=%b rdata=%h total=%0d want 0/1/1/0/0/2",
        busy, o_rv, o_err, o_wb, o_rdata, total);
    end
    // size 3 is illegal on a 32-bit bus even when aligned
    s_req_valid = 1; s_req_size = 2'd3; s_req_addr = 32'h8000_1000; s_req_rd = 5'd3;
    @(negedge clk);
    s_req_valid = 0;
    saw_mem = s_mem_valid;
    n_cmp++;
    if (s_rsp_valid !== 1'b1 || s_rsp_err !== 1'b1 || s_rsp_wb !== 1'b0 || saw_mem !== 1'b0) begin
      n_err++; $display("FAIL size3_on_32: got valid=%b err=%b wb=%b mem_valid=%b want 1/1/0/0",
        s_rsp_valid, s_rsp_err, s_rsp_wb, saw_mem);
    end
    s_rsp_ready = 1; @(negedge clk); s_rsp_ready = 0;
    // aligned signed word load on the 32-bit bus
    s_req_valid = 1; s_req_size = 2'd2; s_req_addr = 32'h0000_0104; s_req_we = 0;
    @(negedge clk);
    s_req_valid = 0;
    n_cmp++;
    if (s_mem_valid !== 1'b1 || s_mem_addr !== 32'h0000_0104 || s_mem_wmask !== 4'h0) begin
      n_err++; $display("FAIL word_load_32_mem: got valid=%b addr=%h mask=%h want 1/00000104/0",
        s_mem_valid, s_mem_addr, s_mem_wmask);
    end
    s_mem_ack = 1; s_mem_rdata = 32'h8000_0001;
    @(negedge clk);
    s_mem_ack = 0;
    n_cmp++;
    if (s_rsp_valid !== 1'b1 || s_rsp_rdata !== 32'h8000_0001 || s_rsp_wb !== 1'b1 || s_rsp_err !== 1'b0) begin
      n_err++; $display("FAIL word_load_32_rsp: got valid=%b rdata=%h wb=%b err=%b want 1/80000001/1/0",
        s_rsp_valid, s_rsp_rdata, s_rsp_wb, s_rsp_err);
    end
    s_rsp_ready = 1; @(negedge clk); s_rsp_ready = 0;
  endtask

  task automatic test_timeout();
    run_access(0, 2'd3, 0, 64'h8000_2000, 64'h0, 5'd1, 0, 64'h0, 0,
      busy, o_addr, o_wdata, o_mask, o_we, o_rv, o_rdata, o_rd, o_wb, o_err, o_stable, o_rdy, total);
    n_cmp++;
    if (busy != TO || o_err !== 1'b1 || o_rdata !== 64'h0 || o_wb !== 1'b0 || o_rv !== 1'b1) begin
      n_err++; $display("FAIL timeout_no_ack: got busy=%0d err=%b rdata=%h wb=%b valid=%b want %0d/1/0/0/1",
        busy, o_err, o_rdata, o_wb, o_rv, TO);
    end
    run_access(0, 2'd3, 0, 64'h8000_2000, 64'h0, 5'd1, TO, 64'hDEAD_BEEF_0BAD_F00D, 0,
      busy, o_addr, o_wdata, o_mask, o_we, o_rv, o_rdata, o_rd, o_wb, o_err, o_stable, o_rdy, total);
    n_cmp++;
    if (busy != TO || o_err !== 1'b0 || o_rdata !== 64'hDEAD_BEEF_0BAD_F00D || o_wb !== 1'b1) begin
      n_err++; $display("FAIL timeout_ack_last: got busy=%0d err=%b rdata=%h wb=%b want %0d/0/deadbeef0badf00d/1",
        busy, o_err, o_rdata, o_wb, TO);
    end
  endtask

  task automatic test_back_to_back();
    run_access(0, 2'd2, 1, 64'h8000_3004, 64'h0, 5'd12, 1, 64'hF000_0001_0000_0000, 3,
      busy, o_addr, o_wdata, o_mask, o_we, o_rv, o_rdata, o_rd, o_wb, o_err, o_stable, o_rdy, total);
    n_cmp++;
    if (o_stable !== 1'b1 || o_rdy !== 1'b1 || o_rdata !== 64'hF000_0001 || o_rd !== 5'd12) begin
      n_err++; $display("FAIL backpressure: got stable=%b ready_after=%b rdata=%h rd=%0d want 1/1/f0000001/12",
        o_stable, o_rdy, o_rdata, o_rd);
    end
    for (int k = 0; k < 2; k++) begin
      run_access(0, 2'd3, 0, 64'h8000_4000 + 64'(8*k), 64'h0, 5'(k), 1, 64'h0123_4567_89AB_CDEF, 0,
        busy, o_addr, o_wdata, o_mask, o_we, o_rv, o_rdata, o_rd, o_wb, o_err, o_stable, o_rdy, total);
      n_cmp++;
      if (total != 3 || o_rdata !== 64'h0123_4567_89AB_CDEF || o_rdy !== 1'b1) begin
        n_err++; $display("FAIL back_to_back_%0d: got cycles=%0d rdata=%h ready=%b want 3/0123456789abcdef/1",
          k, total, o_rdata, o_rdy);
      end
    end
  endtask

  task automatic test_reset_mid();
    req_we = 1; req_size = 2'd2; req_addr = 64'h8000_5004; req_wdata = 64'hCAFE_F00D;
    req_rd = 5'd17; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    n_cmp++;
    if (mem_valid !== 1'b1 || mem_wmask !== 8'hF0) begin
      n_err++; $display("FAIL reset_mid_pre: got mem_valid=%b mask=%h want 1/f0", mem_valid, mem_wmask);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask, rsp_valid, rsp_rdata, rsp_rd, rsp_wb, rsp_err} !== '0
        || req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_async: got mem_valid=%b we=%b addr=%h wdata=%h mask=%h rsp_valid=%b ready=%b want 0s, ready=1",
        mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask, rsp_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_access(0, 2'd1, 0, 64'h8000_5002, 64'h0, 5'd2, 1, 64'h0000_0000_9876_0000, 0,
      busy, o_addr, o_wdata, o_mask, o_we, o_rv, o_rdata, o_rd, o_wb, o_err, o_stable, o_rdy, total);
    n_cmp++;
    if (o_rdata !== 64'hFFFF_FFFF_FFFF_9876 || o_err !== 1'b0 || o_wb !== 1'b1 || total != 3) begin
      n_err++; $display("FAIL reset_mid_after: got rdata=%h err=%b wb=%b cycles=%0d want ffffffffffff9876/0/1/3",
        o_rdata, o_err, o_wb, total);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      bit we = 1'($urandom % 2);
      int size = int'($urandom % 4);
      bit uns = 1'($urandom % 2);
      logic [63:0] addr = {32'h8000_0000, $urandom};
      logic [63:0] wd = {$urandom, $urandom};
      logic [63:0] rdv = {$urandom, $urandom};
      logic [4:0] rd = 5'($urandom);
      int ack = $urandom_range(1, 5);
      bit mis, err;
      int ofs, exp_busy;
      logic [63:0] exp_rdata;
      if ($urandom % 4 != 0) addr = addr & ~((64'd1 << size) - 64'd1);
      ofs = int'(addr % 8);
      mis = ref_misaligned(addr, size);
      err = mis || (ack > TO);
      exp_busy = mis ? 0 : ((ack > TO) ? TO : ack);
      exp_rdata = (!we && !err) ? ref_load(rdv, ofs, size, uns) : 64'h0;
      run_access(we, 2'(size), uns, addr, wd, rd, ack, rdv, 0,
        busy, o_addr, o_wdata, o_mask, o_we, o_rv, o_rdata, o_rd, o_wb, o_err, o_stable, o_rdy, total);
      n_cmp++;
      if (busy != exp_busy || o_err !== err || o_wb !== (!we && !err) || o_rdata !== exp_rdata ||
          o_rd !== rd || o_rv !== 1'b1 || o_rdy !== 1'b1) begin
        n_err++; $display("FAIL random_rsp it=%0d: got busy=%0d err=%b wb=%b rdata=%h rd=%0d want %0d/%b/%b/%h/%0d",
          it, busy, o_err, o_wb, o_rdata, o_rd, exp_busy, err, (!we && !err), exp_rdata, rd);
      end
      if (!mis) begin
        n_cmp++;
        if (o_addr !== (addr & ~64'h7) || o_we !== we || o_stable !== 1'b1 ||
            o_mask !== (we ? ref_mask(ofs, size) : 8'h00) ||
            o_wdata !== (we ? ref_wdata(wd, ofs, size) : 64'h0)) begin
          n_err++; $display("FAIL random_mem it=%0d: got addr=%h we=%b mask=%h wdata=%h stable=%b want %h/%b/%h/%h/1",
            it, o_addr, o_we, o_mask, o_wdata, o_stable, addr & ~64'h7, we,
            we ? ref_mask(ofs, size) : 8'h00, we ? ref_wdata(wd, ofs, size) : 64'h0);
        end
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1;
    @(negedge clk);
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
